// File: rtl/hyper_pkg.sv
// Shared constants for the HyperBus responder: command/address field positions,
// FSM encoding and register-space constants.
package hyper_pkg;

    localparam int CA_READ   = 47;
    localparam int CA_REG    = 46;
    localparam int CA_LINEAR = 45;
    localparam int CA_CR_SEL = 0;

    localparam logic [15:0] CR0_RST      = 16'h8F1F;
    localparam logic [31:0] REG_ID0_ADDR = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CA,
        ST_LAT,
        ST_WDATA,
        ST_RDATA,
        ST_REGW
    } state_e;

    // Word address is the row/upper column field concatenated with the low column bits.
    function automatic logic [31:0] ca_word_addr(input logic [47:0] ca);
        return {ca[44:16], ca[2:0]};
    endfunction

endpackage

// File: rtl/hyper_target_mem.sv
// Internal 16-bit word array: byte-enabled synchronous write, combinational read.
module hyper_target_mem #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic [1:0]    we_be_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [15:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [15:0]   rdata_o
);

    logic [15:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (we_be_i[i]) begin
                mem_q[waddr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hyper_target.sv
// HyperBus device-side responder: decodes CA, signals/counts latency, then
// accepts masked DDR writes or streams reads with an RWDS strobe.
module hyper_target
    import hyper_pkg::*;
#(
    parameter int          MEM_AW     = 10,
    parameter int          LATENCY_CK = 6,
    parameter int          FIXED_LAT  = 1,
    parameter logic [15:0] ID0        = 16'h0C81
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        hb_cs_l,
    input  logic        hb_ck,
    input  logic [7:0]  hb_dq_in,
    output logic [7:0]  hb_dq_out,
    output logic        hb_dq_oe_l,
    input  logic        hb_rwds_in,
    output logic        hb_rwds_out,
    output logic        hb_rwds_oe_l,
    input  logic        force_2x,
    output logic        busy,
    output logic [15:0] cr0
);

    localparam logic [7:0] LAT_1X = 8'(2 * LATENCY_CK);
    localparam logic [7:0] LAT_2X = 8'(4 * LATENCY_CK);

    state_e              state_q;
    logic                ck_q;
    logic [39:0]         ca_q;
    logic [2:0]          cnt_q;
    logic [7:0]          lat_q;
    logic [MEM_AW-1:0]   addr_q;
    logic                m2_q;
    logic                rd_q;
    logic                reg_q;
    logic                lin_q;
    logic                crsel_q;
    logic                reg_zero_q;
    logic [7:0]          hi_q;
    logic                hi_mask_q;
    logic                half_q;
    logic                regw_done_q;
    logic [7:0]          dq_out_q;
    logic                dq_oe_l_q;
    logic                rwds_out_q;
    logic                rwds_oe_l_q;
    logic                busy_q;
    logic [15:0]         cr0_q;

    logic                beat;
    logic [47:0]         ca_full;
    logic [31:0]         ca_waddr;
    logic                ca_rsvd_unused;
    logic [MEM_AW-1:0]   addr_d;
    logic [MEM_AW-1:0]   rd_addr;
    logic [15:0]         mem_rdata;
    logic [15:0]         rd_word;
    logic                mem_we;
    logic [1:0]          mem_be;

    assign beat           = hb_ck ^ ck_q;
    assign ca_full        = {ca_q, hb_dq_in};
    assign ca_waddr       = ca_word_addr(ca_full);
    assign ca_rsvd_unused = ^ca_full[15:3];

    // Wrapped bursts stay inside the aligned 16-word group.
    assign addr_d = lin_q ? addr_q + 1'b1
                          : {addr_q[MEM_AW-1:4], addr_q[3:0] + 4'd1};

    // A falling read beat presents the next word, so look it up one address ahead.
    assign rd_addr = (state_q == ST_RDATA && beat && !hb_ck) ? addr_d : addr_q;
    assign rd_word = reg_q ? (reg_zero_q ? ID0 : cr0_q) : mem_rdata;

    assign mem_we = (state_q == ST_WDATA) && beat && !hb_ck && half_q && !hb_cs_l;
    assign mem_be = {~hi_mask_q, ~hb_rwds_in} & {2{mem_we}};

    hyper_target_mem #(
        .AW (MEM_AW)
    ) u_mem (
        .clk     (clk),
        .we_be_i (mem_be),
        .waddr_i (addr_q),
        .wdata_i ({hi_q, hb_dq_in}),
        .raddr_i (rd_addr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            ck_q        <= 1'b0;
            ca_q        <= '0;
            cnt_q       <= '0;
            lat_q       <= '0;
            addr_q      <= '0;
            m2_q        <= 1'b0;
            rd_q        <= 1'b0;
            reg_q       <= 1'b0;
            lin_q       <= 1'b0;
            crsel_q     <= 1'b0;
            reg_zero_q  <= 1'b0;
            hi_q        <= '0;
            hi_mask_q   <= 1'b0;
            half_q      <= 1'b0;
            regw_done_q <= 1'b0;
            dq_out_q    <= '0;
            dq_oe_l_q   <= 1'b1;
            rwds_out_q  <= 1'b0;
            rwds_oe_l_q <= 1'b1;
            busy_q      <= 1'b0;
            cr0_q       <= CR0_RST;
        end else begin
            ck_q   <= hb_ck;
            busy_q <= (state_q != ST_IDLE);
            if (hb_cs_l) begin
                // Deselect wins over any beat seen on the same clk.
                if (state_q != ST_IDLE) begin
                    state_q     <= ST_IDLE;
                    dq_oe_l_q   <= 1'b1;
                    rwds_oe_l_q <= 1'b1;
                    rwds_out_q  <= 1'b0;
                    half_q      <= 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        state_q     <= ST_CA;
                        cnt_q       <= '0;
                        half_q      <= 1'b0;
                        regw_done_q <= 1'b0;
                        m2_q        <= (FIXED_LAT != 0) || force_2x;
                        rwds_oe_l_q <= 1'b0;
                        rwds_out_q  <= (FIXED_LAT != 0) || force_2x;
                    end
                    ST_CA: begin
                        if (beat) begin
                            ca_q  <= ca_full[39:0];
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd5) begin
                                rwds_oe_l_q <= 1'b1;
                                rwds_out_q  <= 1'b0;
                                rd_q        <= ca_full[CA_READ];
                                reg_q       <= ca_full[CA_REG];
                                lin_q       <= ca_full[CA_LINEAR];
                                crsel_q     <= ca_full[CA_CR_SEL];
                                reg_zero_q  <= (ca_waddr == REG_ID0_ADDR);
                                addr_q      <= ca_waddr[MEM_AW-1:0];
                                lat_q       <= m2_q ? LAT_2X : LAT_1X;
                                if (!ca_full[CA_READ] && ca_full[CA_REG]) begin
                                    state_q <= ST_REGW;
                                end else begin
                                    state_q <= ST_LAT;
                                end
                            end
                        end
                    end
                    ST_LAT: begin
                        if (beat) begin
                            if (lat_q == 8'd1) begin
                                if (rd_q) begin
                                    state_q     <= ST_RDATA;
                                    dq_oe_l_q   <= 1'b0;
                                    rwds_oe_l_q <= 1'b0;
                                    dq_out_q    <= rd_word[15:8];
                                    rwds_out_q  <= 1'b1;
                                end else begin
                                    state_q <= ST_WDATA;
                                    half_q  <= 1'b0;
                                end
                            end else begin
                                lat_q <= lat_q - 8'd1;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (beat) begin
                            if (hb_ck) begin
                                hi_q      <= hb_dq_in;
                                hi_mask_q <= hb_rwds_in;
                                half_q    <= 1'b1;
                            end else if (half_q) begin
                                addr_q <= addr_d;
                                half_q <= 1'b0;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (beat) begin
                            if (hb_ck) begin
                                dq_out_q   <= rd_word[7:0];
                                rwds_out_q <= 1'b0;
                            end else begin
                                addr_q     <= addr_d;
                                dq_out_q   <= rd_word[15:8];
                                rwds_out_q <= 1'b1;
                            end
                        end
                    end
                    ST_REGW: begin
                        if (beat && !regw_done_q) begin
                            if (hb_ck) begin
                                hi_q   <= hb_dq_in;
                                half_q <= 1'b1;
                            end else if (half_q) begin
                                regw_done_q <= 1'b1;
                                if (!crsel_q) begin
                                    cr0_q <= {hi_q, hb_dq_in};
                                end
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign hb_dq_out    = dq_out_q;
    assign hb_dq_oe_l   = dq_oe_l_q;
    assign hb_rwds_out  = rwds_out_q;
    assign hb_rwds_oe_l = rwds_oe_l_q;
    assign busy         = busy_q;
    assign cr0          = cr0_q;

endmodule

// File: tb/tb_hyper_target.sv
// Directed bench for hyper_target: two instances (fixed and variable latency)
// share the initiator pins; expected values are hand-computed constants.
module tb_hyper_target;

    logic        clk = 1'b0;
    logic        reset_l = 1'b0;
    logic        hb_cs_l = 1'b1;
    logic        hb_ck = 1'b0;
    logic [7:0]  hb_dq_in = 8'h00;
    logic        hb_rwds_in = 1'b0;
    logic        force_2x = 1'b0;

    logic [7:0]  dq_out, d0_dq_out;
    logic        dq_oe_l, d0_dq_oe_l;
    logic        rwds_out, d0_rwds_out;
    logic        rwds_oe_l, d0_rwds_oe_l;
    logic        busy, d0_busy;
    logic [15:0] cr0, d0_cr0;

    int n_checks = 0;
    int n_errors = 0;

    logic ca_rwds, ca_rwds_oe_l, d0_ca_rwds;

    always #5 clk = ~clk;

    hyper_target #(
        .MEM_AW(10), .LATENCY_CK(6), .FIXED_LAT(1), .ID0(16'h0C81)
    ) dut (
        .clk          (clk),
        .reset_l      (reset_l),
        .hb_cs_l      (hb_cs_l),
        .hb_ck        (hb_ck),
        .hb_dq_in     (hb_dq_in),
        .hb_dq_out    (dq_out),
        .hb_dq_oe_l   (dq_oe_l),
        .hb_rwds_in   (hb_rwds_in),
        .hb_rwds_out  (rwds_out),
        .hb_rwds_oe_l (rwds_oe_l),
        .force_2x     (force_2x),
        .busy         (busy),
        .cr0          (cr0)
    );

    hyper_target #(
        .MEM_AW(10), .LATENCY_CK(6), .FIXED_LAT(0), .ID0(16'h0C81)
    ) dut0 (
        .clk          (clk),
        .reset_l      (reset_l),
        .hb_cs_l      (hb_cs_l),
        .hb_ck        (hb_ck),
        .hb_dq_in     (hb_dq_in),
        .hb_dq_out    (d0_dq_out),
        .hb_dq_oe_l   (d0_dq_oe_l),
        .hb_rwds_in   (hb_rwds_in),
        .hb_rwds_out  (d0_rwds_out),
        .hb_rwds_oe_l (d0_rwds_oe_l),
        .force_2x     (force_2x),
        .busy         (d0_busy),
        .cr0          (d0_cr0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // One beat = toggle CK with data, then a quiet clk; outputs are stable on return.
    task automatic beat(input logic [7:0] d, input logic r);
        hb_ck      = ~hb_ck;
        hb_dq_in   = d;
        hb_rwds_in = r;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic cs_start();
        hb_cs_l = 1'b0;
        @(negedge clk);
    endtask

    // Deselect, then park CK low while idle so the next CA starts on a rising beat.
    task automatic cs_end();
        hb_cs_l = 1'b1;
        @(negedge clk);
        if (hb_ck) hb_ck = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic send_ca(input logic [47:0] ca);
        for (int i = 0; i < 6; i++) begin
            beat(ca[47-8*i -: 8], 1'b0);
            if (i == 0) begin
                ca_rwds      = rwds_out;
                ca_rwds_oe_l = rwds_oe_l;
                d0_ca_rwds   = d0_rwds_out;
            end
        end
    endtask

    task automatic lat_beats(input int n);
        for (int i = 0; i < n; i++) beat(8'h00, 1'b0);
    endtask

    // Beats until the fixed-latency DUT drives DQ; returns -1 on timeout.
    task automatic wait_rd(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            beat(8'h00, 1'b0);
            if (!dq_oe_l) begin
                n = i;
                break;
            end
        end
    endtask

    // Fixed 30 beats; records the first beat each DUT starts driving DQ.
    task automatic measure(output int n, output int n0);
        n  = -1;
        n0 = -1;
        for (int i = 1; i <= 30; i++) begin
            beat(8'h00, 1'b0);
            if (!dq_oe_l && n < 0) n = i;
            if (!d0_dq_oe_l && n0 < 0) n0 = i;
        end
    endtask

    task automatic write2(input logic [47:0] ca, input logic [15:0] w0, input logic [15:0] w1);
        cs_start();
        send_ca(ca);
        lat_beats(24);
        beat(w0[15:8], 1'b0);
        beat(w0[7:0], 1'b0);
        beat(w1[15:8], 1'b0);
        beat(w1[7:0], 1'b0);
        cs_end();
    endtask

    initial begin
        int n, n0;

        @(negedge clk);
        repeat (3) @(negedge clk);
        check("rst_dq_oe_l", dq_oe_l, 1);
        check("rst_rwds_oe_l", rwds_oe_l, 1);
        check("rst_busy", busy, 0);
        check("rst_cr0", cr0, 16'h8F1F);
        check("rst_outs", {dq_out, rwds_out}, 9'h000);
        check("rst_d0", {d0_dq_out, d0_dq_oe_l, d0_rwds_out, d0_rwds_oe_l, d0_busy},
              {8'h00, 1'b1, 1'b0, 1'b1, 1'b0});
        check("rst_d0_cr0", d0_cr0, 16'h8F1F);
        reset_l = 1'b1;
        @(negedge clk);

        $display("txn write addr=005 A1B2 C3D4");
        cs_start();
        send_ca(48'h00_0000_0000_05);
        check("ca_rwds_2x", ca_rwds, 1);
        check("ca_rwds_oe", ca_rwds_oe_l, 0);
        check("ca_rwds_release", rwds_oe_l, 1);
        lat_beats(24);
        beat(8'hA1, 1'b0); beat(8'hB2, 1'b0);
        beat(8'hC3, 1'b0); beat(8'hD4, 1'b0);
        check("wr_busy", busy, 1);
        cs_end();
        check("wr_busy_drop", busy, 0);
        check("wr_mem5", dut.u_mem.mem_q[5], 16'hA1B2);
        check("wr_mem6", dut.u_mem.mem_q[6], 16'hC3D4);

        $display("txn read addr=005 x4 bytes");
        cs_start();
        send_ca(48'h80_0000_0000_05);
        check("rd_oe_ca", dq_oe_l, 1);
        wait_rd(n);
        check("rd_latency", n, 24);
        check("rd_b0", {dq_out, rwds_out}, {8'hA1, 1'b1});
        beat(8'h00, 1'b0);
        check("rd_b1", {dq_out, rwds_out}, {8'hB2, 1'b0});
        beat(8'h00, 1'b0);
        check("rd_b2", {dq_out, rwds_out}, {8'hC3, 1'b1});
        beat(8'h00, 1'b0);
        check("rd_b3", {dq_out, rwds_out}, {8'hD4, 1'b0});
        check("rd_oe_data", {dq_oe_l, rwds_oe_l}, 2'b00);
        cs_end();
        check("rd_oe_end", {dq_oe_l, rwds_oe_l}, 2'b11);

        $display("txn masked write addr=005 FFFF lower masked");
        cs_start();
        send_ca(48'h00_0000_0000_05);
        lat_beats(24);
        beat(8'hFF, 1'b0); beat(8'hFF, 1'b1);
        cs_end();
        check("mask_mem5", dut.u_mem.mem_q[5], 16'hFFB2);

        $display("txn latency force_2x=0");
        force_2x = 1'b0;
        cs_start();
        send_ca(48'h80_0000_0000_05);
        measure(n, n0);
        check("lat1x_rwds", d0_ca_rwds, 0);
        check("lat1x_beats", n0, 12);
        check("lat_fixed_beats", n, 24);
        cs_end();

        $display("txn latency force_2x=1");
        force_2x = 1'b1;
        cs_start();
        send_ca(48'h80_0000_0000_05);
        measure(n, n0);
        check("lat2x_rwds", d0_ca_rwds, 1);
        check("lat2x_beats", n0, 24);
        cs_end();
        force_2x = 1'b0;

        $display("txn reg write cr0=8F0F");
        cs_start();
        send_ca(48'h60_0001_0000_00);
        beat(8'h8F, 1'b0); beat(8'h0F, 1'b0);
        check("regw_cr0", cr0, 16'h8F0F);
        beat(8'h11, 1'b0); beat(8'h22, 1'b0);
        cs_end();
        check("regw_cr0_hold", cr0, 16'h8F0F);
        check("regw_d0_cr0", d0_cr0, 16'h8F0F);

        $display("txn reg read addr=0 (ID0)");
        cs_start();
        send_ca(48'hC0_0000_0000_00);
        wait_rd(n);
        check("regr_latency", n, 24);
        check("regr_hi", dq_out, 8'h0C);
        beat(8'h00, 1'b0);
        check("regr_lo", dq_out, 8'h81);
        cs_end();

        $display("txn write addr=020 1111 2222");
        write2(48'h00_0000_0400_00, 16'h1111, 16'h2222);
        $display("txn aborted write addr=020 after 3 bytes");
        cs_start();
        send_ca(48'h00_0000_0400_00);
        lat_beats(24);
        beat(8'h55, 1'b0); beat(8'h66, 1'b0); beat(8'h77, 1'b0);
        check("abort_busy", busy, 1);
        cs_end();
        check("abort_busy_drop", busy, 0);
        check("abort_mem20", dut.u_mem.mem_q[32], 16'h5566);
        check("abort_mem21", dut.u_mem.mem_q[33], 16'h2222);

        $display("txn wrapped write addr=00F BEEF CAFE");
        write2(48'h00_0000_0100_07, 16'hBEEF, 16'hCAFE);
        check("wrapw_mem0f", dut.u_mem.mem_q[15], 16'hBEEF);
        check("wrapw_mem00", dut.u_mem.mem_q[0], 16'hCAFE);

        $display("txn wrapped read addr=00F");
        cs_start();
        send_ca(48'h80_0000_0100_07);
        wait_rd(n);
        check("wrapr_latency", n, 24);
        check("wrapr_b0", dq_out, 8'hBE);
        beat(8'h00, 1'b0);
        check("wrapr_b1", dq_out, 8'hEF);
        beat(8'h00, 1'b0);
        check("wrapr_b2", dq_out, 8'hCA);
        beat(8'h00, 1'b0);
        check("wrapr_b3", dq_out, 8'hFE);
        cs_end();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/hyper_target.md
Name: hyper_target

Overview:
Synthesizable HyperBus responder (HyperRAM device side) for the other end of hyper_xface. It decodes the 6-byte CA phase, signals latency on RWDS and counts the latency. It then accepts masked DDR write bytes into an internal 16-bit memory, or drives read bytes with an RWDS strobe. It is used as the loopback target in benches and on FPGA images without a physical part.

Parameters:
MEM_AW, 10, word-address width of internal array (2^MEM_AW x 16-bit words)
LATENCY_CK, 6, initial latency in CK periods
FIXED_LAT, 1, 1 = always double latency; 0 = double only when force_2x is high at CA start
ID0, 16'h0C81, value returned for register-space reads at address 0

Ports:
clk  in  1  system clock; samples all HyperBus pins
reset_l  in  1  asynchronous, active-low reset
hb_cs_l  in  1  chip select, active low
hb_ck  in  1  HyperBus CK, changes at most once per clk
hb_dq_in  in  8  DQ from initiator
hb_dq_out  out  8  DQ to initiator
hb_dq_oe_l  out  1  DQ output enable, active low
hb_rwds_in  in  1  RWDS from initiator (write byte mask)
hb_rwds_out  out  1  RWDS driven by target
hb_rwds_oe_l  out  1  RWDS output enable, active low
force_2x  in  1  request double latency (refresh collision) when FIXED_LAT=0
busy  out  1  high while the FSM is not in IDLE
cr0  out  16  configuration register 0, written through register space

Behaviour:
- Reset: hb_dq_out=0, hb_dq_oe_l=1, hb_rwds_out=0, hb_rwds_oe_l=1, busy=0, cr0=16'h8F1F, FSM=IDLE, array contents undefined.
- Beat detection: hb_ck is registered. Each clk where hb_ck differs from its previous sample is one beat. Beat level 1 = rising edge, level 0 = falling edge.
- IDLE: hb_cs_l sampled low -> CA with beat count 0. Latch m=2 if FIXED_LAT or force_2x, else m=1. Drive hb_rwds_oe_l=0 and hb_rwds_out=(m==2) from the next clk until CA ends.
- CA: capture hb_dq_in on 6 beats, MSB first, into ca[47:0].
  - ca[47]=read, ca[46]=register space, ca[45]=linear burst (0 = wrapped).
  - Word address = {ca[44:16], ca[2:0]}, truncated to MEM_AW.
  - After the 6th beat: release RWDS. Register-space write -> REGW (zero latency). Otherwise -> LAT, counter = 2*LATENCY_CK*m beats.
- LAT: decrement per beat. On the last latency beat, a write goes to WDATA. A read goes to RDATA and, on the same clk, registers hb_dq_oe_l=0, hb_rwds_oe_l=0, hb_dq_out=word[15:8], hb_rwds_out=1.
- WDATA: a rising beat captures the upper byte and its mask (hb_rwds_in=1 means masked). The following falling beat captures the lower byte and mask, writes the enabled bytes to mem[addr] on that clk, then increments addr.
- RDATA: each beat advances one byte. A rising beat presents the lower byte with rwds_out=0; a falling beat presents the next word's upper byte with rwds_out=1. Output is registered one clk after beat detection. Read data is fetched combinationally from the array.
- REGW: 2 beats form one word. The word is written to cr0 only if ca[0]=0 (CR0, word address 0x800 subset). Further beats are ignored.
- Register-space read: goes through LAT/RDATA. Returns ID0 when address==0, cr0 otherwise.
- Address increment: linear bursts wrap at 2^MEM_AW. Wrapped bursts wrap within an aligned 16-word group, keeping addr[MEM_AW-1:4].
- hb_cs_l high in any state returns the FSM to IDLE on the next clk and deasserts both oe_l.
  - A half-captured write word is discarded; completed words stay written.
  - A CS deassert in the same clk as a beat wins: that beat is ignored.
- busy deasserts on the clk after returning to IDLE.

Decomposition:
- Package hyper_pkg: CA field bit positions, FSM state encoding, cr0 reset value, register address constants.
- One sub-module hyper_target_mem: 2^MEM_AW x 16 array with a 2-bit byte-enable write port and a combinational read port.

Test Plan:
- Memory write: CA 0x00_0000_0000_0005, two words 0xA1B2 and 0xC3D4, masks 0 -> after CS high, backdoor mem[5]=0xA1B2 and mem[6]=0xC3D4. With FIXED_LAT=1, LATENCY_CK=6, data starts after exactly 24 beats.
- Masked write: word 0xFFFF to addr 5 with RWDS high on the lower byte -> mem[5]=0xFF B2.
- Read: CA 0x80_0000_0000_0005 -> rwds_out toggles 1,0,1,0 with bytes A1,B2,C3,D4. dq_oe_l is low only during RDATA.
- Latency select: FIXED_LAT=0, force_2x=0 -> RWDS low during CA and 12-beat latency. force_2x=1 -> RWDS high and 24 beats.
- Register space: write CA 0x60_0001_0000_0000 with data 0x8F0F (zero latency) -> cr0=0x8F0F. Read at address 0 -> bytes 0x0C, 0x81.
- Abort/wrap: CS high after 3 write bytes -> only the first word is written and busy drops. Wrapped read starting at word 0x0F returns words 0x0F then 0x00.
